stream_packet_arbiter: RTL and testbench
========================================

Name: stream_packet_arbiter

Overview:
- Shares one packet-stream consumer (the string-matching engine) between NUM_SOURCES packet-stream producers.
- Arbitration is packet-atomic round-robin. Once a source is granted, every beat from its SOP to its EOP is forwarded uninterrupted.
- A registered output stage and a packet counter are included.
- Sits directly upstream of the matching engine's stream_in.

Parameters:
- NUM_SOURCES, 4: number of requesting streams, 2..16.
- DATA_WIDTH, 64: beat data width in bits, a multiple of 8. Matches the consumer's DATA_WIDTH.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8) (min 1): width of the empty-bytes field.
- CHAN_WIDTH, $clog2(NUM_SOURCES) (min 1): width of the channel/grant index.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  NUM_SOURCES  per-source beat valid.
- in_ready  out  NUM_SOURCES  per-source beat accept.
- in_data  in  NUM_SOURCES*DATA_WIDTH  per-source data, source i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_sop  in  NUM_SOURCES  per-source start-of-packet.
- in_eop  in  NUM_SOURCES  per-source end-of-packet.
- in_empty  in  NUM_SOURCES*EMPTY_WIDTH  per-source unused bytes in the EOP beat.
- out_valid  out  1  forwarded beat valid.
- out_ready  in  1  consumer accept.
- out_data  out  DATA_WIDTH  forwarded data.
- out_sop  out  1  forwarded SOP.
- out_eop  out  1  forwarded EOP.
- out_empty  out  EMPTY_WIDTH  forwarded empty.
- out_channel  out  CHAN_WIDTH  index of the source of the current beat.
- pkt_count  out  32  packets forwarded, i.e. EOP beats accepted by the consumer.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Transfer rule: a beat transfers when valid && ready on the same edge. A source must hold valid, data, sop, eop and empty stable until accepted.
- Reset values (reset=0, async):
  - out_valid=0, out_data=0, out_sop=0, out_eop=0, out_empty=0, out_channel=0.
  - in_ready=0, pkt_count=0, proto_err=0.
  - State=IDLE, round-robin pointer rr_ptr=0.
  - Deassertion is synchronised into the clk domain by the integrator, not by this block.
- State machine, state IDLE:
  - in_ready is all-zero.
  - If any in_valid[i]=1, the grant goes to the first i with in_valid set, searching i = rr_ptr, rr_ptr+1, ..., modulo NUM_SOURCES.
  - On that edge: register grant=i, go to LOCKED.
  - With no requests, stay in IDLE.
- State machine, state LOCKED:
  - in_ready[grant] = (!out_valid || out_ready). All other in_ready bits are 0.
  - An accepted beat with in_eop[grant]=1 sets rr_ptr=(grant+1) mod NUM_SOURCES and returns to IDLE on the same edge.
- Output stage: a single register stage.
  - On each accepted input beat, load out_* from the granted source, set out_channel=grant and set out_valid=1.
  - If out_valid && out_ready and no new beat is accepted, clear out_valid. Data fields hold their last value.
  - Full throughput of 1 beat/cycle within a packet, including when the output stalls and releases.
- Latency:
  - From in_valid rising in IDLE to the first out_valid: 2 cycles (1 arbitration cycle plus 1 register cycle).
  - Within a packet: 1 cycle.
  - One idle bubble cycle on the input side between consecutive packets (the IDLE cycle).
- Single-beat packets (sop=eop=1) are legal: a 1-beat lock, then IDLE.
- First granted beat with sop=0:
  - Forward it unchanged and set proto_err=1.
  - The lock still holds until EOP.
- Beat with sop=1 inside a locked packet (not the first beat):
  - Forward it unchanged and set proto_err=1.
- proto_err clears only on reset.
- pkt_count increments by 1 on each out_valid && out_ready && out_eop, and wraps from 2^32-1 to 0.
- Source in_valid dropping mid-packet: legal (idle beats). The lock holds and no other source is served.
- Ungranted sources: their in_ready stays 0 regardless of in_valid. There is no timeout or starvation bypass.
- Reset mid-packet: the in-flight output beat is lost and the source's remaining beats wait for re-arbitration. Recovery is the integrator's responsibility.

Test Plan:
- Single source 0 sends a 3-beat packet (data 0x11, 0x22, 0x33, empty=5 on EOP), out_ready=1:
  - out_valid first rises 2 cycles after in_valid.
  - Beats appear on consecutive cycles with out_channel=0.
  - out_empty=5 on the EOP beat; pkt_count=1.
- Sources 0 and 2 hold 2-beat packets continuously, NUM_SOURCES=4:
  - Output packet order is 0, 2, 0, 2.
  - Beats are never interleaved within a packet.
  - After 4 packets, pkt_count=4.
- out_ready toggles 1,0,0,1,1 during a 4-beat packet from source 1:
  - No beat is lost or duplicated; data order is preserved.
  - in_ready[1]=0 exactly while out_valid=1 and out_ready=0.
- Back-to-back single-beat packets from source 3 only:
  - Input accepted every other cycle (IDLE bubble).
  - out_sop=out_eop=1 on each beat; pkt_count tracks the count exactly.
- Source 0 starts with sop=0, then sends a later beat with sop=1 before EOP:
  - proto_err=1 and all beats are forwarded.
  - proto_err stays 1 until reset=0, then reads 0.
- Assert reset=0 on beat 2 of 4 from source 2:
  - All outputs are 0 asynchronously, before the next edge.
  - After release, source 2 re-arbitrates with rr_ptr=0.

Source files
------------

// File: rtl/stream_packet_arbiter.sv
//==============================================================================
// stream_packet_arbiter : packet-atomic round-robin mux of N streams to one sink
// Revision: 1.0
//==============================================================================
`default_nettype none

module stream_packet_arbiter #(
   parameter int NUM_SOURCES = 4,
   parameter int DATA_WIDTH  = 64,
   parameter int EMPTY_WIDTH = (DATA_WIDTH / 8 > 1) ? $clog2(DATA_WIDTH / 8) : 1,
   parameter int CHAN_WIDTH  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_SOURCES-1:0]             in_valid,
   output logic [NUM_SOURCES-1:0]             in_ready,
   input  logic [NUM_SOURCES*DATA_WIDTH-1:0]  in_data,
   input  logic [NUM_SOURCES-1:0]             in_sop,
   input  logic [NUM_SOURCES-1:0]             in_eop,
   input  logic [NUM_SOURCES*EMPTY_WIDTH-1:0] in_empty,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [DATA_WIDTH-1:0]              out_data,
   output logic                               out_sop,
   output logic                               out_eop,
   output logic [EMPTY_WIDTH-1:0]             out_empty,
   output logic [CHAN_WIDTH-1:0]              out_channel,
   output logic [31:0]                        pkt_count,
   output logic                               proto_err
);

   localparam logic [CHAN_WIDTH-1:0] LAST_SRC = CHAN_WIDTH'(NUM_SOURCES - 1);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [CHAN_WIDTH-1:0]   grant;
   logic [CHAN_WIDTH-1:0]   grant_next;
   logic [CHAN_WIDTH-1:0]   rr_ptr;
   logic                    found;
   logic                    first_beat;
   logic                    take;
   logic                    accept;
   int                      arb_idx;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    sel_sop;
   logic                    sel_eop;
   logic [EMPTY_WIDTH-1:0]  sel_empty;

   // Output register can take a new beat when empty or being drained this edge
   assign take      = !out_valid || out_ready;
   assign sel_data  = in_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_empty = in_empty[int'(grant)*EMPTY_WIDTH +: EMPTY_WIDTH];
   assign sel_sop   = in_sop[grant];
   assign sel_eop   = in_eop[grant];
   assign accept    = (state == LOCKED) && in_valid[grant] && take;

   // Search downwards so the lowest offset from rr_ptr wins
   always_comb begin
      found      = 1'b0;
      grant_next = rr_ptr;
      arb_idx    = 0;
      for (int k = NUM_SOURCES - 1; k >= 0; k--) begin
         arb_idx = (int'(rr_ptr) + k) % NUM_SOURCES;
         if (in_valid[CHAN_WIDTH'(arb_idx)]) begin
            found      = 1'b1;
            grant_next = CHAN_WIDTH'(arb_idx);
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (state == LOCKED) begin
         in_ready[grant] = take;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (found) state_next = LOCKED;
         LOCKED:  if (accept && sel_eop) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant       <= '0;
         rr_ptr      <= '0;
         first_beat  <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_sop     <= 1'b0;
         out_eop     <= 1'b0;
         out_empty   <= '0;
         out_channel <= '0;
         pkt_count   <= '0;
         proto_err   <= 1'b0;
      end else begin
         if (state == IDLE && found) begin
            grant      <= grant_next;
            first_beat <= 1'b1;
         end
         if (accept) begin
            first_beat  <= 1'b0;
            out_valid   <= 1'b1;
            out_data    <= sel_data;
            out_sop     <= sel_sop;
            out_eop     <= sel_eop;
            out_empty   <= sel_empty;
            out_channel <= grant;
            // Only the first beat of a lock may, and must, carry SOP
            if (first_beat != sel_sop) begin
               proto_err <= 1'b1;
            end
            if (sel_eop) begin
               rr_ptr <= (grant == LAST_SRC) ? '0 : grant + 1'b1;
            end
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (out_valid && out_ready && out_eop) begin
            pkt_count <= pkt_count + 32'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stream_packet_arbiter.sv
//==============================================================================
// tb_stream_packet_arbiter : scoreboard bench for stream_packet_arbiter
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_stream_packet_arbiter;

   localparam int NS = 4;
   localparam int DW = 64;
   localparam int EW = 3;
   localparam int CW = 2;
   localparam int OW = DW + 2 + EW + CW;

   logic              clk;
   logic              reset;
   logic [NS-1:0]     in_valid;
   logic [NS-1:0]     in_ready;
   logic [NS*DW-1:0]  in_data;
   logic [NS-1:0]     in_sop;
   logic [NS-1:0]     in_eop;
   logic [NS*EW-1:0]  in_empty;
   logic              out_valid;
   logic              out_ready;
   logic [DW-1:0]     out_data;
   logic              out_sop;
   logic              out_eop;
   logic [EW-1:0]     out_empty;
   logic [CW-1:0]     out_channel;
   logic [31:0]       pkt_count;
   logic              proto_err;

   stream_packet_arbiter #(
      .NUM_SOURCES (NS),
      .DATA_WIDTH  (DW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_empty    (in_empty),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_sop     (out_sop),
      .out_eop     (out_eop),
      .out_empty   (out_empty),
      .out_channel (out_channel),
      .pkt_count   (pkt_count),
      .proto_err   (proto_err)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic          sop;
      logic          eop;
      logic [EW-1:0] empty;
   } beat_t;

   typedef struct {
      int            src;
      int            nbeats;
      logic [DW-1:0] base;
      logic [DW-1:0] step;
      int            empty;
      logic [7:0]    rdy;
      int            nrdy;
      int            exp_lat;
      int            exp_span;
      int            exp_pkt;
   } vec_t;

   beat_t          srcq [NS][$];
   logic [OW-1:0]  sb[$];
   logic           rdyq[$];
   int             order[$];
   int             acc3[$];

   int             total = 0;
   int             bad = 0;
   int             cyc = 0;
   int             exp_pkt = 0;
   int             lock = -1;
   int             first_ov_cyc = -1;
   int             last_eop_cyc = -1;
   logic [NS-1:0]  acc_pend = '0;
   logic           mon_inpkt = 1'b0;
   logic [CW-1:0]  mon_chan = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #2;
   endtask

   task automatic push_beat(input int s, input logic [DW-1:0] d, input logic sop,
                            input logic eop, input int emp);
      beat_t b;
      b.data  = d;
      b.sop   = sop;
      b.eop   = eop;
      b.empty = EW'(emp);
      srcq[s].push_back(b);
   endtask

   function automatic logic busy();
      logic any = 1'b0;
      for (int s = 0; s < NS; s++) if (srcq[s].size() != 0) any = 1'b1;
      return any || (sb.size() != 0) || out_valid || (acc_pend != '0);
   endfunction

   task automatic drain(input int maxc);
      int n = 0;
      sync();
      while (busy() && n < maxc) begin
         sync();
         n++;
      end
      if (busy()) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got busy after %0d cycles expected idle", maxc);
         for (int s = 0; s < NS; s++) srcq[s].delete();
         sb.delete();
      end
      rdyq.delete();
   endtask

   // Driver, acceptance tracker and output monitor, all stepped on the falling edge
   initial begin
      beat_t          b;
      logic [OW-1:0]  act_b;
      logic [OW-1:0]  exp_b;
      logic [NS-1:0]  exp_rdy;
      in_valid  = '0;
      in_data   = '0;
      in_sop    = '0;
      in_eop    = '0;
      in_empty  = '0;
      out_ready = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) chk("pkt_count", 64'(pkt_count), 64'(exp_pkt));
         for (int s = 0; s < NS; s++) begin
            if (acc_pend[s]) begin
               b = srcq[s].pop_front();
               sb.push_back({b.data, b.sop, b.eop, b.empty, CW'(s)});
               if (s == 3) acc3.push_back(cyc);
               lock = b.eop ? -1 : s;
            end
         end
         out_ready = (rdyq.size() > 0) ? rdyq.pop_front() : 1'b1;
         for (int s = 0; s < NS; s++) begin
            if (srcq[s].size() > 0) begin
               in_valid[s]              = 1'b1;
               in_data[s*DW +: DW]      = srcq[s][0].data;
               in_sop[s]                = srcq[s][0].sop;
               in_eop[s]                = srcq[s][0].eop;
               in_empty[s*EW +: EW]     = srcq[s][0].empty;
            end else begin
               in_valid[s]              = 1'b0;
               in_data[s*DW +: DW]      = '0;
               in_sop[s]                = 1'b0;
               in_eop[s]                = 1'b0;
               in_empty[s*EW +: EW]     = '0;
            end
         end
         #1;
         acc_pend = in_valid & in_ready;
         if (reset) begin
            if (lock >= 0) begin
               exp_rdy = (!out_valid || out_ready) ? (NS'(1) << lock) : '0;
               chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            end else begin
               chk("in_ready_onehot", 64'($countones(in_ready) <= 1), 64'(1));
            end
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (out_valid && out_ready) begin
               act_b = {out_data, out_sop, out_eop, out_empty, out_channel};
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL sb_underflow: got beat %h expected none", act_b);
               end else begin
                  exp_b = sb.pop_front();
                  if (act_b !== exp_b) begin
                     bad++;
                     $display("FAIL out_beat: got %h expected %h", act_b, exp_b);
                  end
               end
               if (mon_inpkt) begin
                  chk("no_interleave", 64'(out_channel), 64'(mon_chan));
               end else begin
                  order.push_back(int'(out_channel));
                  mon_chan = out_channel;
               end
               mon_inpkt = !out_eop;
               if (out_eop) begin
                  exp_pkt++;
                  last_eop_cyc = cyc;
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab[4];
      int   present;
      int   n;
      int   exp_order[4];
      tab[0] = '{0, 3, 64'h11, 64'h11, 5, 8'h00, 0, 2, 4, 1};
      tab[1] = '{1, 4, 64'hA000_0000_0000_0001, 64'h1, 2, 8'h19, 5, 2, 6, 2};
      tab[2] = '{3, 1, 64'hDEAD, 64'h0, 7, 8'h00, 0, 2, 2, 3};
      tab[3] = '{2, 2, 64'h1234, 64'h100, 3, 8'h03, 3, 2, 4, 4};

      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_pkt_count", 64'(pkt_count), 64'(0));
      chk("rst_proto_err", 64'(proto_err), 64'(0));
      chk("rst_out_data", out_data, 64'(0));
      @(negedge clk);
      #3;
      reset = 1'b1;

      // Isolated packets: latency, span to EOP, running packet count
      for (int r = 0; r < 4; r++) begin
         sync();
         present      = cyc + 1;
         first_ov_cyc = -1;
         for (int k = 0; k < tab[r].nrdy; k++) rdyq.push_back(tab[r].rdy[k]);
         for (int k = 0; k < tab[r].nbeats; k++)
            push_beat(tab[r].src, tab[r].base + DW'(k) * tab[r].step, k == 0,
                      k == tab[r].nbeats - 1, (k == tab[r].nbeats - 1) ? tab[r].empty : 0);
         drain(60);
         chk("latency", 64'(first_ov_cyc - present), 64'(tab[r].exp_lat));
         chk("span", 64'(last_eop_cyc - present), 64'(tab[r].exp_span));
         chk("tab_pkt_count", 64'(pkt_count), 64'(tab[r].exp_pkt));
         chk("tab_proto_err", 64'(proto_err), 64'(0));
      end

      // Two contending sources, two 2-beat packets each
      sync();
      order.delete();
      for (int p = 0; p < 2; p++) begin
         for (int k = 0; k < 2; k++) begin
            push_beat(0, 64'h5500_0000 + DW'(p * 16 + k), k == 0, k == 1, 0);
            push_beat(2, 64'h5500_0200 + DW'(p * 16 + k), k == 0, k == 1, 1);
         end
      end
      drain(80);
      exp_order = '{0, 2, 0, 2};
      chk("order_len", 64'(order.size()), 64'(4));
      for (int i = 0; i < 4 && i < order.size(); i++) chk("rr_order", 64'(order[i]), 64'(exp_order[i]));
      chk("arb_pkt_count", 64'(pkt_count), 64'(8));

      // Back-to-back single-beat packets from source 3
      sync();
      acc3.delete();
      for (int k = 0; k < 4; k++) push_beat(3, 64'hC0DE_0000 + DW'(k), 1'b1, 1'b1, k);
      drain(60);
      chk("b2b_count", 64'(acc3.size()), 64'(4));
      for (int i = 1; i < 4 && i < acc3.size(); i++) chk("b2b_gap", 64'(acc3[i] - acc3[i-1]), 64'(2));
      chk("b2b_pkt_count", 64'(pkt_count), 64'(12));

      // Missing SOP on first beat, stray SOP mid-packet
      chk("proto_before", 64'(proto_err), 64'(0));
      sync();
      push_beat(0, 64'hE0, 1'b0, 1'b0, 0);
      push_beat(0, 64'hE1, 1'b0, 1'b0, 0);
      push_beat(0, 64'hE2, 1'b1, 1'b0, 0);
      push_beat(0, 64'hE3, 1'b0, 1'b1, 4);
      drain(60);
      chk("proto_set", 64'(proto_err), 64'(1));
      chk("proto_pkt_count", 64'(pkt_count), 64'(13));
      sync();
      push_beat(2, 64'hF0, 1'b1, 1'b0, 0);
      push_beat(2, 64'hF1, 1'b0, 1'b1, 6);
      drain(60);
      chk("proto_sticky", 64'(proto_err), 64'(1));

      // Reset on beat 2 of a 4-beat packet from source 2
      sync();
      for (int k = 0; k < 4; k++) push_beat(2, 64'h7700 + DW'(k), k == 0, k == 3, (k == 3) ? 2 : 0);
      n = 0;
      do begin
         @(negedge clk);
         #3;
         n++;
      end while (srcq[2].size() != 3 && n < 40);
      chk("reset_wait", 64'(n < 40), 64'(1));
      reset = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'(0));
      chk("arst_out_data", out_data, 64'(0));
      chk("arst_out_flags", 64'({out_sop, out_eop, out_empty, out_channel}), 64'(0));
      chk("arst_in_ready", 64'(in_ready), 64'(0));
      chk("arst_pkt_count", 64'(pkt_count), 64'(0));
      chk("arst_proto_err", 64'(proto_err), 64'(0));
      sb.delete();
      acc_pend  = '0;
      lock      = -1;
      exp_pkt   = 0;
      mon_inpkt = 1'b0;
      order.delete();
      push_beat(3, 64'h3333, 1'b1, 1'b1, 1);
      repeat (2) @(negedge clk);
      #3;
      reset = 1'b1;
      drain(60);
      chk("rearb_len", 64'(order.size()), 64'(2));
      if (order.size() >= 2) begin
         chk("rearb_first", 64'(order[0]), 64'(2));
         chk("rearb_second", 64'(order[1]), 64'(3));
      end
      chk("rearb_pkt_count", 64'(pkt_count), 64'(2));
      chk("rearb_proto_err", 64'(proto_err), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
